// File: rtl/hc595_writer.sv
// hc595_writer
//   Drives a daisy-chained 74HC595 string. A one-cycle Load in IDLE captures
//   Dat, which is then shifted out MSB-first on SerDat/SerClk. After the last
//   bit the storage latch SerLt is pulsed. The '595 outputs are then enabled
//   through SerOe_n, which stays low from that point on.
//
//   Handshake: Load is a request that is honoured only while Busy=0; Dat is
//   sampled in that accept cycle only. Load while Busy=1 is dropped, not
//   queued. Done pulses for one cycle when the word has been latched. The
//   Done cycle is already IDLE, so a held Load chains transfers with no gap.
//
// Ports
//   Clk        system clock, rising edge
//   Reset      synchronous reset, active-high
//   Dat        word to send (WIDTH bits)
//   Load       transfer request
//   Busy       high from the cycle after accept until the Done cycle
//   Done       one-cycle pulse when the word has been latched
//   SerClk     '595 SRCLK
//   SerDat     '595 SER
//   SerLt      '595 RCLK (storage latch)
//   SerOe_n    '595 nOE, active-low
//   dbg_state  current FSM state, for observation only
module hc595_writer #(
  parameter int WIDTH = 16,
  parameter int DIV   = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Dat,
  input  logic             Load,
  output logic             Busy,
  output logic             Done,
  output logic             SerClk,
  output logic             SerDat,
  output logic             SerLt,
  output logic             SerOe_n,
  output logic [1:0]       dbg_state
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SH_LO = 2'd1,
    SH_HI = 2'd2,
    LATCH = 2'd3
  } state_t;

  state_t            state;
  logic [DW-1:0]     div_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [WIDTH-1:0]  shreg;
  logic              tick;

  assign tick      = (div_cnt == DW'(DIV - 1));
  assign dbg_state = state;

  // The bit currently on the wire is always the MSB of the shift register,
  // so SerDat comes straight from a flop. Shifting happens only on the
  // SH_HI->SH_LO step, which is also the falling edge of SerClk.
  assign SerDat = shreg[WIDTH-1];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      SerClk  <= 1'b0;
      SerLt   <= 1'b0;
      SerOe_n <= 1'b1;
    end else begin
      Done <= 1'b0;

      // Phase divider: free-runs 0..DIV-1 outside IDLE and is held at zero
      // in IDLE, so every transfer starts on a full phase.
      if (state == IDLE || tick) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end

      case (state)
        IDLE: begin
          if (Load) begin
            shreg   <= Dat;
            bit_cnt <= '0;
            Busy    <= 1'b1;
            state   <= SH_LO;
          end
        end

        SH_LO: begin
          if (tick) begin
            SerClk <= 1'b1;
            state  <= SH_HI;
          end
        end

        SH_HI: begin
          if (tick) begin
            SerClk <= 1'b0;
            if (bit_cnt == BW'(WIDTH - 1)) begin
              SerLt <= 1'b1;
              state <= LATCH;
            end else begin
              shreg   <= shreg << 1;
              bit_cnt <= bit_cnt + BW'(1);
              state   <= SH_LO;
            end
          end
        end

        LATCH: begin
          if (tick) begin
            SerLt   <= 1'b0;
            Done    <= 1'b1;
            SerOe_n <= 1'b0;
            Busy    <= 1'b0;
            state   <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hc595_writer.sv
module tb_hc595_writer;

  typedef struct packed {
    logic busy;
    logic done;
    logic sclk;
    logic sdat;
    logic slt;
    logic oe_n;
  } obs_t;

  typedef struct {
    int          sel;
    logic [15:0] dat;
    int          glitch;
    int          exp_lat;
    int          exp_rises;
    logic [15:0] exp_bits;
    int          exp_lt;
    logic        exp_oe_prev;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  initial forever #5 clk = ~clk;

  // instance a: WIDTH=16 DIV=4, instance b: WIDTH=8 DIV=1
  logic [15:0] dat_a = '0;
  logic        load_a = 1'b0;
  logic [7:0]  dat_b = '0;
  logic        load_b = 1'b0;
  logic busy_a, done_a, sclk_a, sdat_a, slt_a, oe_a;
  logic busy_b, done_b, sclk_b, sdat_b, slt_b, oe_b;
  logic [1:0] dbg_a, dbg_b;

  hc595_writer #(.WIDTH(16), .DIV(4)) u_dut_a (
    .Clk(clk), .Reset(rst), .Dat(dat_a), .Load(load_a),
    .Busy(busy_a), .Done(done_a), .SerClk(sclk_a), .SerDat(sdat_a),
    .SerLt(slt_a), .SerOe_n(oe_a), .dbg_state(dbg_a)
  );

  hc595_writer #(.WIDTH(8), .DIV(1)) u_dut_b (
    .Clk(clk), .Reset(rst), .Dat(dat_b), .Load(load_b),
    .Busy(busy_b), .Done(done_b), .SerClk(sclk_b), .SerDat(sdat_b),
    .SerLt(slt_b), .SerOe_n(oe_b), .dbg_state(dbg_b)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic obs_t get_obs(input int sel);
    if (sel == 0) return {busy_a, done_a, sclk_a, sdat_a, slt_a, oe_a};
    return {busy_b, done_b, sclk_b, sdat_b, slt_b, oe_b};
  endfunction

  // Reference waveform of one transfer, d cycles after its accept cycle.
  // Phases are DIV long: odd phases carry SerClk high, bit i occupies phases
  // 2i and 2i+1, then one latch phase, then Done.
  function automatic obs_t model_out(input int w, input int dv, input logic [15:0] word,
                                     input int d, input bit have);
    obs_t e;
    int   i;
    e = '0;
    if (!have) return e;
    e.busy = (d >= 1) && (d <= 2*w*dv + dv);
    e.done = (d == 2*w*dv + dv + 1);
    e.slt  = (d > 2*w*dv) && (d <= 2*w*dv + dv);
    e.sclk = (d <= 2*w*dv) && ((((d - 1) / dv) % 2) == 1);
    i = (d - 1) / (2*dv);
    if (i > w - 1) i = w - 1;
    e.sdat = word[w-1-i];
    return e;
  endfunction

  // scoreboard: per-cycle comparison of both instances against the model
  bit          have[2]      = '{0, 0};
  int          tacc[2]      = '{0, 0};
  logic [15:0] word[2]      = '{16'h0, 16'h0};
  bit          done_seen[2] = '{0, 0};
  int          cyc          = 0;

  initial begin
    obs_t e;
    obs_t o;
    logic ld;
    forever begin
      @(negedge clk);
      cyc++;
      for (int k = 0; k < 2; k++) begin
        e = model_out((k == 0) ? 16 : 8, (k == 0) ? 4 : 1, word[k], cyc - tacc[k], have[k]);
        if (e.done) done_seen[k] = 1'b1;
        e.oe_n = !done_seen[k];
        o = get_obs(k);
        if (chk_en) check((k == 0) ? "model_a" : "model_b", 32'(o), 32'(e));
        ld = (k == 0) ? load_a : load_b;
        if (rst) begin
          have[k]      = 1'b0;
          done_seen[k] = 1'b0;
        end else if (!e.busy && ld) begin
          have[k] = 1'b1;
          tacc[k] = cyc;
          word[k] = (k == 0) ? dat_a : {8'h00, dat_b};
        end
      end
    end
  end

  // driver: one transfer, observed until Done (bounded)
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load(input int sel, input logic v, input logic [15:0] d);
    if (sel == 0) begin
      load_a = v;
      dat_a  = d;
    end else begin
      load_b = v;
      dat_b  = d[7:0];
    end
  endtask

  task automatic run_vec(input int sel, input logic [15:0] dat, input int glitch_at,
                         output int lat, output int rises, output logic [15:0] bits,
                         output int lt_cyc, output logic oe_prev);
    obs_t o;
    logic prev_sclk;
    logic last_oe;
    lat = -1; rises = 0; bits = '0; lt_cyc = 0; oe_prev = 1'bx;
    tick();
    set_load(sel, 1'b1, dat);
    o = get_obs(sel);
    prev_sclk = o.sclk;
    last_oe   = o.oe_n;
    for (int n = 1; n <= 400; n++) begin
      tick();
      if (n == 1) set_load(sel, 1'b0, dat);
      if (glitch_at > 1 && n == glitch_at) set_load(sel, 1'b1, 16'hFFFF);
      if (glitch_at > 1 && n == glitch_at + 1) set_load(sel, 1'b0, 16'hFFFF);
      o = get_obs(sel);
      if (o.sclk && !prev_sclk) begin
        rises++;
        bits = {bits[14:0], o.sdat};
      end
      prev_sclk = o.sclk;
      if (o.slt) lt_cyc++;
      if (o.done) begin
        lat = n;
        oe_prev = last_oe;
        check("oe_at_done", 32'(o.oe_n), 32'd0);
        break;
      end
      last_oe = o.oe_n;
    end
    set_load(sel, 1'b0, dat);
  endtask

  vec_t vecs[6];

  initial begin
    int          lat, rises, lt_cyc, toggles, ndone, d1, d2;
    logic [15:0] bits, bits1, bits2;
    logic        oe_prev, prev;

    vecs[0] = '{0, 16'hA55A, 0,  133, 16, 16'hA55A, 4, 1'b1};
    vecs[1] = '{0, 16'hA55A, 40, 133, 16, 16'hA55A, 4, 1'b0};
    vecs[2] = '{0, 16'h0001, 0,  133, 16, 16'h0001, 4, 1'b0};
    vecs[3] = '{0, 16'hFFFF, 0,  133, 16, 16'hFFFF, 4, 1'b0};
    vecs[4] = '{1, 16'h0081, 0,  18,  8,  16'h0081, 1, 1'b1};
    vecs[5] = '{1, 16'h003C, 0,  18,  8,  16'h003C, 1, 1'b0};

    // reset
    rst = 1'b1;
    repeat (3) tick();
    chk_en = 1'b1;
    rst = 1'b0;
    check("rst_sclk", 32'(sclk_a), 32'd0);
    check("rst_sdat", 32'(sdat_a), 32'd0);
    check("rst_slt",  32'(slt_a),  32'd0);
    check("rst_oe_n", 32'(oe_a),   32'd1);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_state", 32'(dbg_a), 32'd0);

    // idle with Load low: nothing moves
    toggles = 0;
    prev = sclk_a;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (sclk_a != prev || sclk_b) toggles++;
      prev = sclk_a;
    end
    check("idle_toggles", 32'(toggles), 32'd0);
    check("idle_oe_n", 32'({oe_a, oe_b}), 32'd3);

    // table-driven transfers
    foreach (vecs[i]) begin
      run_vec(vecs[i].sel, vecs[i].dat, vecs[i].glitch, lat, rises, bits, lt_cyc, oe_prev);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d_rises", i), 32'(rises), 32'(vecs[i].exp_rises));
      check($sformatf("v%0d_bits", i), 32'(bits), 32'(vecs[i].exp_bits));
      check($sformatf("v%0d_latch_cycles", i), 32'(lt_cyc), 32'(vecs[i].exp_lt));
      check($sformatf("v%0d_oe_before_done", i), 32'(oe_prev), 32'(vecs[i].exp_oe_prev));
      if (vecs[i].glitch > 0) begin
        ndone = 0;
        for (int n = 0; n < 150; n++) begin
          tick();
          if (done_a) ndone++;
        end
        check("ignored_load_no_done", 32'(ndone), 32'd0);
      end
    end

    // held Load: back-to-back transfers, Dat changes after first accept
    tick();
    load_a = 1'b1;
    dat_a = 16'h0001;
    d1 = -1; d2 = -1; bits1 = '0; bits2 = '0;
    prev = sclk_a;
    for (int n = 1; n <= 400; n++) begin
      tick();
      if (n == 1) dat_a = 16'h8000;
      if (d1 > 0 && n == d1 + 1) load_a = 1'b0;
      if (sclk_a && !prev) begin
        if (d1 < 0) bits1 = {bits1[14:0], sdat_a};
        else        bits2 = {bits2[14:0], sdat_a};
      end
      prev = sclk_a;
      if (done_a) begin
        if (d1 < 0) d1 = n;
        else begin
          d2 = n;
          break;
        end
      end
    end
    load_a = 1'b0;
    check("b2b_first_done", 32'(d1), 32'd133);
    check("b2b_done_gap", 32'(d2 - d1), 32'd133);
    check("b2b_bits1", 32'(bits1), 32'h0001);
    check("b2b_bits2", 32'(bits2), 32'h8000);

    // reset in cycle t+50 of a transfer
    tick();
    load_a = 1'b1;
    dat_a = 16'hA55A;
    for (int n = 1; n <= 50; n++) begin
      tick();
      if (n == 1) load_a = 1'b0;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst", 32'({sclk_a, sdat_a, slt_a, oe_a, busy_a}), 32'b00010);
    run_vec(0, 16'h1234, 0, lat, rises, bits, lt_cyc, oe_prev);
    check("post_rst_latency", 32'(lat), 32'd133);
    check("post_rst_bits", 32'(bits), 32'h1234);
    check("post_rst_oe_before_done", 32'(oe_prev), 32'd1);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      tick();
      rst    = ($urandom_range(0, 299) == 0);
      load_a = ($urandom_range(0, 7) == 0);
      dat_a  = 16'($urandom);
      load_b = ($urandom_range(0, 3) == 0);
      dat_b  = 8'($urandom);
    end
    tick();
    rst = 1'b0;
    load_a = 1'b0;
    load_b = 1'b0;
    repeat (200) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
